// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - instruction fetch bus between sequencer and instruction memory
interface alu_seq_ctrl_if #(
  parameter int AW = 8
) ();
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic [15:0]   instr_rdata;
  logic          instr_valid;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_rdata,
    input  instr_valid
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_rdata,
    output instr_valid
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multicycle fetch/decode/execute sequencer for the ALU datapath
module alu_seq_ctrl #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  alu_seq_ctrl_if.master       ibus,
  input  logic                 zero,
  output logic                 write_enable,
  output logic                 ALUSrc,
  output logic [1:0]           ALUControl,
  output logic [3:0]           RA1,
  output logic [3:0]           RA2,
  output logic [3:0]           WA,
  output logic [7:0]           immediate,
  output logic                 busy,
  output logic                 halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_BNZ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t        state;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [3:0]    op;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] br_target;
  logic [AW-1:0] next_pc;

  assign op        = ir[15:12];
  assign pc_inc    = pc + AW'(1);
  // Branch offset is an 8-bit two's complement displacement relative to the branch itself.
  assign br_target = pc + AW'($signed(ir[7:0]));

  // The fetch port is a pure decode of the state register so reset clears it immediately.
  assign ibus.instr_req  = (state == FETCH);
  assign ibus.instr_addr = pc;

  // Select the PC that follows the instruction currently in EXEC.
  always_comb begin
    next_pc = pc_inc;
    case (op)
      OP_BZ:   next_pc = zero  ? br_target : pc_inc;
      OP_BNZ:  next_pc = !zero ? br_target : pc_inc;
      OP_JMP:  next_pc = ir[AW-1:0];
      default: next_pc = pc_inc;
    endcase
  end

  // Sequencer FSM: owns PC, IR and the registered busy/halted status flags.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        FETCH: begin
          if (ibus.instr_valid) begin
            ir    <= ibus.instr_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          pc <= next_pc;
          if (op == OP_HALT) begin
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls are decoded from IR only while in EXEC and are zero otherwise.
  always_comb begin
    write_enable = 1'b0;
    ALUSrc       = 1'b0;
    ALUControl   = 2'b00;
    RA1          = 4'h0;
    RA2          = 4'h0;
    WA           = 4'h0;
    immediate    = 8'h00;
    if (state == EXEC) begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          RA1          = ir[7:4];
          RA2          = ir[3:0];
          WA           = ir[11:8];
          write_enable = 1'b1;
          ALUControl   = 2'(op - OP_ADD);
        end
        OP_ADDI, OP_ANDI, OP_ORI: begin
          RA1          = ir[11:8];
          WA           = ir[11:8];
          ALUSrc       = 1'b1;
          immediate    = ir[7:0];
          write_enable = 1'b1;
          ALUControl   = (op == OP_ADDI) ? 2'b00 : (op == OP_ANDI) ? 2'b10 : 2'b11;
        end
        OP_BZ, OP_BNZ: begin
          // rs OR 0 drives the zero flag from the register value alone.
          RA1        = ir[11:8];
          ALUSrc     = 1'b1;
          ALUControl = 2'b11;
        end
        default: begin
          write_enable = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed table-driven bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       zero;
  logic       we;
  logic       alu_src;
  logic [1:0] alu_ctl;
  logic [3:0] ra1, ra2, wa;
  logic [7:0] imm;
  logic       busy;
  logic       halted;

  int total_cnt;
  int pass_cnt;

  alu_seq_ctrl_if #(.AW(8)) ibus ();

  alu_seq_ctrl #(.AW(8), .RESET_PC(8'h00)) dut (
    .CLK          (clk),
    .reset        (rst),
    .start        (start),
    .ibus         (ibus),
    .zero         (zero),
    .write_enable (we),
    .ALUSrc       (alu_src),
    .ALUControl   (alu_ctl),
    .RA1          (ra1),
    .RA2          (ra2),
    .WA           (wa),
    .immediate    (imm),
    .busy         (busy),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    int          delay;
    logic        zero;
    logic        we;
    logic        src;
    logic [1:0]  ctl;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa;
    logic [7:0]  imm;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl_zero(input string name);
    chk({name, ".we"},  32'(we), 32'd0);
    chk({name, ".ctl"}, {17'd0, alu_src, alu_ctl, ra1, ra2, wa, imm}, 32'd0);
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    start = 1'b0;
    zero = 1'b0;
    ibus.instr_valid = 1'b0;
    ibus.instr_rdata = 16'h0000;

    //           addr   instr     dly z  we src ctl   ra1   ra2   wa    imm
    vecs[0]  = '{8'h00, 16'h5105, 0, 0, 1, 1, 2'b00, 4'h1, 4'h0, 4'h1, 8'h05};
    vecs[1]  = '{8'h01, 16'h1213, 3, 0, 1, 0, 2'b00, 4'h1, 4'h3, 4'h2, 8'h00};
    vecs[2]  = '{8'h02, 16'h2456, 0, 0, 1, 0, 2'b01, 4'h5, 4'h6, 4'h4, 8'h00};
    vecs[3]  = '{8'h03, 16'h6A0F, 1, 0, 1, 1, 2'b10, 4'hA, 4'h0, 4'hA, 8'h0F};
    vecs[4]  = '{8'h04, 16'h84FE, 0, 1, 0, 1, 2'b11, 4'h4, 4'h0, 4'h0, 8'h00};
    vecs[5]  = '{8'h02, 16'h3789, 0, 0, 1, 0, 2'b10, 4'h8, 4'h9, 4'h7, 8'h00};
    vecs[6]  = '{8'h03, 16'h7B80, 0, 0, 1, 1, 2'b11, 4'hB, 4'h0, 4'hB, 8'h80};
    vecs[7]  = '{8'h04, 16'h84FE, 0, 0, 0, 1, 2'b11, 4'h4, 4'h0, 4'h0, 8'h00};
    vecs[8]  = '{8'h05, 16'h4CDE, 2, 0, 1, 0, 2'b11, 4'hD, 4'hE, 4'hC, 8'h00};
    vecs[9]  = '{8'h06, 16'h9305, 0, 0, 0, 1, 2'b11, 4'h3, 4'h0, 4'h0, 8'h00};
    vecs[10] = '{8'h0B, 16'hA0FF, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[11] = '{8'hFF, 16'h0000, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[12] = '{8'h00, 16'hC123, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[13] = '{8'h01, 16'hA040, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[14] = '{8'h40, 16'hF000, 0, 0, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00};

    tick();
    tick();
    chk("rst.req",    32'(ibus.instr_req), 32'd0);
    chk("rst.addr",   32'(ibus.instr_addr), 32'd0);
    chk("rst.busy",   32'(busy), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk_ctrl_zero("rst");
    rst = 1'b0;
    tick();
    chk("idle.req", 32'(ibus.instr_req), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("v%0d.req", i),  32'(ibus.instr_req), 32'd1);
      chk($sformatf("v%0d.addr", i), 32'(ibus.instr_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d.fbusy", i), 32'(busy), 32'd1);
      for (int d = 0; d < vecs[i].delay; d++) begin
        ibus.instr_valid = 1'b0;
        ibus.instr_rdata = 16'hDEAD;
        tick();
        chk($sformatf("v%0d.wait_req", i),  32'(ibus.instr_req), 32'd1);
        chk($sformatf("v%0d.wait_addr", i), 32'(ibus.instr_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d.wait_we", i),   32'(we), 32'd0);
      end
      ibus.instr_valid = 1'b1;
      ibus.instr_rdata = vecs[i].instr;
      tick();
      ibus.instr_valid = 1'b0;
      ibus.instr_rdata = 16'h0000;
      zero = vecs[i].zero;
      chk($sformatf("v%0d.exec_req", i), 32'(ibus.instr_req), 32'd0);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d.ctl", i),
          {17'd0, we, alu_src, alu_ctl, ra1, ra2, wa, imm},
          {17'd0, vecs[i].we, vecs[i].src, vecs[i].ctl, vecs[i].ra1, vecs[i].ra2,
           vecs[i].wa, vecs[i].imm});
      tick();
      zero = 1'b0;
    end

    // After HALT: halted, idle bus, stray instr_valid and zero ignored.
    for (int k = 0; k < 3; k++) begin
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.busy",   32'(busy), 32'd0);
      chk("halt.req",    32'(ibus.instr_req), 32'd0);
      chk_ctrl_zero("halt");
      ibus.instr_valid = 1'b1;
      tick();
    end
    ibus.instr_valid = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.req",    32'(ibus.instr_req), 32'd1);
    chk("restart.addr",   32'(ibus.instr_addr), 32'd0);
    chk("restart.halted", 32'(halted), 32'd0);
    chk("restart.busy",   32'(busy), 32'd1);

    // start ignored while busy: ADDI then NOP at address 1.
    ibus.instr_valid = 1'b1;
    ibus.instr_rdata = 16'h5105;
    tick();
    ibus.instr_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored.addr", 32'(ibus.instr_addr), 32'd1);

    // Reset asserted mid-EXEC of ADDI.
    ibus.instr_valid = 1'b1;
    ibus.instr_rdata = 16'h5207;
    tick();
    ibus.instr_valid = 1'b0;
    chk("pre_rst.we", 32'(we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.we",   32'(we), 32'd0);
    chk("async_rst.busy", 32'(busy), 32'd0);
    chk("async_rst.req",  32'(ibus.instr_req), 32'd0);
    chk("async_rst.addr", 32'(ibus.instr_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst.busy",   32'(busy), 32'd0);
    chk("post_rst.halted", 32'(halted), 32'd0);
    chk("post_rst.req",    32'(ibus.instr_req), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst.start_addr", 32'(ibus.instr_addr), 32'd0);
    chk("post_rst.start_req",  32'(ibus.instr_req), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
